// File: rtl/nco_sqgen.sv
// nco_sqgen: numerically controlled square-wave generator.
// Phase accumulator with a loadable/rampable step, a one-deep phase-jump slot
// and optional LFSR phase jitter. o_output is the accumulator MSB.
module nco_sqgen #(
  parameter int PHASE_BITS = 32,
  parameter int LFSR_BITS  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_ce,
  input  logic                  i_ld,
  input  logic [PHASE_BITS-2:0] i_step,
  input  logic                  i_ramp_start,
  input  logic [PHASE_BITS-2:0] i_ramp_target,
  input  logic [PHASE_BITS-2:0] i_ramp_rate,
  output logic                  o_ramp_busy,
  input  logic                  i_jump_valid,
  input  logic [PHASE_BITS-1:0] i_jump,
  output logic                  o_jump_ready,
  input  logic                  i_jitter_en,
  input  logic [4:0]            i_lgjitter,
  output logic                  o_output,
  output logic                  o_edge,
  output logic [PHASE_BITS-1:0] o_phase,
  output logic [PHASE_BITS-1:0] o_step
);

  // Fibonacci feedback tap masks (bit n-1 = x^n term) for maximal-length LFSRs.
  function automatic logic [31:0] taps_for(input int n);
    case (n)
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0E08;
      13:      return 32'h0000_1C80;
      14:      return 32'h0000_3802;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0007_2000;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

  localparam logic [LFSR_BITS-1:0] TAPS = LFSR_BITS'(taps_for(LFSR_BITS));

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t                  state_reg;
  logic [PHASE_BITS-1:0]   step_reg, target_reg, rate_reg;
  logic                    busy_reg;
  logic [PHASE_BITS-1:0]   jump_reg;
  logic                    jump_pending_reg, jump_ready_reg;
  logic [PHASE_BITS-1:0]   phase_reg;
  logic                    output_reg, edge_reg;
  logic [LFSR_BITS-1:0]    lfsr_reg;

  logic [PHASE_BITS-1:0]   jit_value, phase_next;
  logic [LFSR_BITS-1:0]    lfsr_next;
  logic                    ramp_up, ramp_done;
  logic [PHASE_BITS-1:0]   ramp_diff, ramp_step;

  // Next accumulator value, jitter term and next LFSR state.
  always_comb begin
    jit_value  = PHASE_BITS'($signed(lfsr_reg)) << i_lgjitter;
    phase_next = phase_reg + step_reg
               + (jump_pending_reg ? jump_reg : '0)
               + (i_jitter_en ? jit_value : '0);
    lfsr_next  = {lfsr_reg[LFSR_BITS-2:0], ^(lfsr_reg & TAPS)};
  end

  // One ramp increment toward the target; lands exactly on it when within one rate.
  always_comb begin
    ramp_up   = (target_reg >= step_reg);
    ramp_diff = ramp_up ? (target_reg - step_reg) : (step_reg - target_reg);
    ramp_done = (ramp_diff <= rate_reg);
    if (ramp_done)
      ramp_step = target_reg;
    else if (ramp_up)
      ramp_step = step_reg + rate_reg;
    else
      ramp_step = step_reg - rate_reg;
  end

  // Step register and ramp FSM; a load always wins and aborts a ramp.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_reg  <= IDLE;
      busy_reg   <= 1'b0;
      step_reg   <= '0;
      target_reg <= '0;
      rate_reg   <= '0;
    end else if (i_ld) begin
      step_reg  <= {1'b0, i_step};
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_ramp_start) begin
            target_reg <= {1'b0, i_ramp_target};
            rate_reg   <= {1'b0, i_ramp_rate};
            state_reg  <= RAMP;
            busy_reg   <= 1'b1;
          end
        end
        RAMP: begin
          if (i_ce) begin
            step_reg <= ramp_step;
            if (ramp_done) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Jump slot: accept, apply on a later i_ce, then reopen one cycle after applying.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      jump_reg         <= '0;
      jump_pending_reg <= 1'b0;
      jump_ready_reg   <= 1'b1;
    end else if (jump_ready_reg && i_jump_valid) begin
      jump_reg         <= i_jump;
      jump_pending_reg <= 1'b1;
      jump_ready_reg   <= 1'b0;
    end else if (jump_pending_reg && i_ce) begin
      jump_pending_reg <= 1'b0;
    end else if (!jump_pending_reg && !jump_ready_reg) begin
      jump_ready_reg <= 1'b1;
    end
  end

  // Accumulator, square-wave output, edge pulse and jitter LFSR advance on i_ce.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      phase_reg  <= '0;
      output_reg <= 1'b0;
      edge_reg   <= 1'b0;
      lfsr_reg   <= LFSR_BITS'(1);
    end else if (i_ce) begin
      phase_reg  <= phase_next;
      output_reg <= phase_next[PHASE_BITS-1];
      edge_reg   <= phase_next[PHASE_BITS-1] ^ output_reg;
      lfsr_reg   <= lfsr_next;
    end else begin
      edge_reg <= 1'b0;
    end
  end

  assign o_phase      = phase_reg;
  assign o_step       = step_reg;
  assign o_output     = output_reg;
  assign o_edge       = edge_reg;
  assign o_ramp_busy  = busy_reg;
  assign o_jump_ready = jump_ready_reg;

endmodule

// File: tb/tb_nco_sqgen.sv
// tb_nco_sqgen: directed checks of the NCO square-wave generator.
module tb_nco_sqgen;

  logic        i_clk = 1'b0;
  logic        i_areset_n = 1'b0;
  logic        i_ce = 1'b0;
  logic        i_ld = 1'b0;
  logic [30:0] i_step = '0;
  logic        i_ramp_start = 1'b0;
  logic [30:0] i_ramp_target = '0;
  logic [30:0] i_ramp_rate = '0;
  logic        o_ramp_busy;
  logic        i_jump_valid = 1'b0;
  logic [31:0] i_jump = '0;
  logic        o_jump_ready;
  logic        i_jitter_en = 1'b0;
  logic [4:0]  i_lgjitter = '0;
  logic        o_output, o_edge;
  logic [31:0] o_phase, o_step;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  nco_sqgen #(.PHASE_BITS(32), .LFSR_BITS(16)) dut (
    .i_clk(i_clk), .i_areset_n(i_areset_n), .i_ce(i_ce), .i_ld(i_ld),
    .i_step(i_step), .i_ramp_start(i_ramp_start), .i_ramp_target(i_ramp_target),
    .i_ramp_rate(i_ramp_rate), .o_ramp_busy(o_ramp_busy),
    .i_jump_valid(i_jump_valid), .i_jump(i_jump), .o_jump_ready(o_jump_ready),
    .i_jitter_en(i_jitter_en), .i_lgjitter(i_lgjitter),
    .o_output(o_output), .o_edge(o_edge), .o_phase(o_phase), .o_step(o_step)
  );

  typedef struct {
    logic        ld;
    logic [30:0] stp;
    logic        rs;
    logic [30:0] tgt;
    logic [30:0] rate;
    logic        ce;
    logic [31:0] exp_step;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_ce = 1'b0; i_ld = 1'b0; i_step = '0; i_ramp_start = 1'b0;
    i_ramp_target = '0; i_ramp_rate = '0; i_jump_valid = 1'b0; i_jump = '0;
    i_jitter_en = 1'b0; i_lgjitter = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_areset_n = 1'b0;
    #3;
    @(negedge i_clk);
    i_areset_n = 1'b1;
  endtask

  task automatic add_vec(input logic ld, input logic [30:0] stp, input logic rs,
                         input logic [30:0] tgt, input logic [30:0] rate, input logic ce,
                         input logic [31:0] exp_step, input logic exp_busy);
    vec_t v;
    v.ld = ld; v.stp = stp; v.rs = rs; v.tgt = tgt; v.rate = rate; v.ce = ce;
    v.exp_step = exp_step; v.exp_busy = exp_busy;
    vecs.push_back(v);
  endtask

  initial begin : main
    logic [15:0] mdl_lfsr;
    logic [31:0] mdl_phase;
    logic [31:0] exp_ph;

    // Ramp / load vectors: {ld, step, ramp_start, target, rate, ce} -> {o_step, o_ramp_busy}
    add_vec(1, 31'h0100_0000, 0, 31'h0, 31'h0, 0, 32'h0100_0000, 0);
    add_vec(0, 31'h0, 1, 31'h0140_0000, 31'h0010_0000, 0, 32'h0100_0000, 1);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 1, 32'h0110_0000, 1);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 1, 32'h0120_0000, 1);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 0, 32'h0120_0000, 1);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 1, 32'h0130_0000, 1);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 1, 32'h0140_0000, 0);
    add_vec(1, 31'h0100_0000, 0, 31'h0, 31'h0, 0, 32'h0100_0000, 0);
    add_vec(0, 31'h0, 1, 31'h0105_0000, 31'h0010_0000, 1, 32'h0100_0000, 1);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 1, 32'h0105_0000, 0);
    add_vec(1, 31'h0100_0000, 0, 31'h0, 31'h0, 0, 32'h0100_0000, 0);
    add_vec(0, 31'h0, 1, 31'h00C0_0000, 31'h0010_0000, 0, 32'h0100_0000, 1);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 1, 32'h00F0_0000, 1);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 1, 32'h00E0_0000, 1);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 1, 32'h00D0_0000, 1);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 1, 32'h00C0_0000, 0);
    add_vec(1, 31'h0050_0000, 1, 31'h0070_0000, 31'h0010_0000, 0, 32'h0050_0000, 0);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 1, 32'h0050_0000, 0);
    add_vec(0, 31'h0, 1, 31'h0070_0000, 31'h0010_0000, 0, 32'h0050_0000, 1);
    add_vec(0, 31'h0, 1, 31'h0010_0000, 31'h0040_0000, 1, 32'h0060_0000, 1);
    add_vec(1, 31'h0200_0000, 0, 31'h0, 31'h0, 1, 32'h0200_0000, 0);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 1, 32'h0200_0000, 0);
    add_vec(0, 31'h0, 1, 31'h0300_0000, 31'h0, 0, 32'h0200_0000, 1);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 1, 32'h0200_0000, 1);
    add_vec(0, 31'h0, 0, 31'h0, 31'h0, 1, 32'h0200_0000, 1);
    add_vec(1, 31'h0, 0, 31'h0, 31'h0, 0, 32'h0000_0000, 0);

    // Reset values
    idle_inputs();
    #12;
    check("rst_phase", o_phase, 32'h0);
    check("rst_step", o_step, 32'h0);
    check("rst_output", {31'h0, o_output}, 32'h0);
    check("rst_edge", {31'h0, o_edge}, 32'h0);
    check("rst_busy", {31'h0, o_ramp_busy}, 32'h0);
    check("rst_ready", {31'h0, o_jump_ready}, 32'h1);
    $display("reset: phase=0x%08h step=0x%08h ready=%0b", o_phase, o_step, o_jump_ready);
    @(negedge i_clk);
    i_areset_n = 1'b1;

    // Square wave: 32 ce per period at step 0x0800_0000
    i_ld = 1'b1; i_step = 31'h0800_0000;
    tick();
    i_ld = 1'b0;
    check("sq_step", o_step, 32'h0800_0000);
    i_ce = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      check($sformatf("sq_out_%0d", k), {31'h0, o_output}, {31'h0, (k >= 16 && k < 32)});
      check($sformatf("sq_edge_%0d", k), {31'h0, o_edge}, {31'h0, (k == 16 || k == 32)});
    end
    check("sq_phase_wrap", o_phase, 32'h0);
    $display("square: phase after 32 ce=0x%08h", o_phase);
    i_ce = 1'b0;

    // Table-driven ramp and load vectors
    for (int i = 0; i < vecs.size(); i++) begin
      i_ld = vecs[i].ld; i_step = vecs[i].stp; i_ramp_start = vecs[i].rs;
      i_ramp_target = vecs[i].tgt; i_ramp_rate = vecs[i].rate; i_ce = vecs[i].ce;
      tick();
      check($sformatf("vec%0d_step", i), o_step, vecs[i].exp_step);
      check($sformatf("vec%0d_busy", i), {31'h0, o_ramp_busy}, {31'h0, vecs[i].exp_busy});
      $display("vec %0d: ld=%0b rs=%0b ce=%0b step=0x%08h busy=%0b", i,
               vecs[i].ld, vecs[i].rs, vecs[i].ce, o_step, o_ramp_busy);
    end
    idle_inputs();

    // Phase jump while i_ce is low
    do_reset();
    i_ld = 1'b1; i_step = 31'h0100_0000;
    tick();
    i_ld = 1'b0; i_ce = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    check("jmp_phase_pre", o_phase, 32'h1000_0000);
    i_ce = 1'b0; i_jump_valid = 1'b1; i_jump = 32'h8000_0000;
    tick();
    i_jump_valid = 1'b0; i_jump = '0;
    check("jmp_ready_low1", {31'h0, o_jump_ready}, 32'h0);
    tick();
    tick();
    check("jmp_ready_low3", {31'h0, o_jump_ready}, 32'h0);
    check("jmp_phase_hold", o_phase, 32'h1000_0000);
    check("jmp_edge_noce", {31'h0, o_edge}, 32'h0);
    i_ce = 1'b1;
    tick();
    i_ce = 1'b0;
    check("jmp_phase_apply", o_phase, 32'h9100_0000);
    check("jmp_output", {31'h0, o_output}, 32'h1);
    check("jmp_edge", {31'h0, o_edge}, 32'h1);
    check("jmp_ready_still_low", {31'h0, o_jump_ready}, 32'h0);
    tick();
    check("jmp_ready_back", {31'h0, o_jump_ready}, 32'h1);
    check("jmp_edge_cleared", {31'h0, o_edge}, 32'h0);
    $display("jump (ce low): phase=0x%08h ready=%0b", o_phase, o_jump_ready);

    // Jump accepted on an i_ce cycle waits for the next i_ce
    i_ce = 1'b1; i_jump_valid = 1'b1; i_jump = 32'h1000_0000;
    tick();
    i_jump_valid = 1'b0; i_jump = '0;
    check("jmp2_phase_accept", o_phase, 32'h9200_0000);
    check("jmp2_ready_low", {31'h0, o_jump_ready}, 32'h0);
    tick();
    check("jmp2_phase_apply", o_phase, 32'hA300_0000);
    i_ce = 1'b0;
    tick();
    check("jmp2_ready_back", {31'h0, o_jump_ready}, 32'h1);
    $display("jump (ce high): phase=0x%08h ready=%0b", o_phase, o_jump_ready);

    // Asynchronous reset mid-ramp with a jump pending
    i_ld = 1'b1; i_step = 31'h0100_0000;
    tick();
    i_ld = 1'b0;
    i_ramp_start = 1'b1; i_ramp_target = 31'h0200_0000; i_ramp_rate = 31'h0010_0000;
    i_jump_valid = 1'b1; i_jump = 32'h0000_1234;
    tick();
    idle_inputs();
    check("ar_busy_pre", {31'h0, o_ramp_busy}, 32'h1);
    check("ar_ready_pre", {31'h0, o_jump_ready}, 32'h0);
    #2;
    i_areset_n = 1'b0;
    #1;
    check("ar_phase", o_phase, 32'h0);
    check("ar_step", o_step, 32'h0);
    check("ar_output", {31'h0, o_output}, 32'h0);
    check("ar_edge", {31'h0, o_edge}, 32'h0);
    check("ar_busy", {31'h0, o_ramp_busy}, 32'h0);
    check("ar_ready", {31'h0, o_jump_ready}, 32'h1);
    $display("async reset: phase=0x%08h step=0x%08h busy=%0b ready=%0b",
             o_phase, o_step, o_ramp_busy, o_jump_ready);
    @(negedge i_clk);
    i_areset_n = 1'b1;
    i_ce = 1'b1;
    tick();
    check("ar_jump_discarded", o_phase, 32'h0);
    check("ar_ramp_discarded", o_step, 32'h0);
    i_ce = 1'b0;

    // Jitter: step 0, lgjitter 8, phase follows a reference LFSR from 1
    do_reset();
    mdl_lfsr = 16'h0001;
    mdl_phase = 32'h0;
    i_jitter_en = 1'b1; i_lgjitter = 5'd8; i_ce = 1'b1;
    for (int n = 0; n < 65535; n++) begin
      tick();
      exp_ph = 32'($signed(mdl_lfsr)) << 8;
      mdl_phase = mdl_phase + exp_ph;
      mdl_lfsr = {mdl_lfsr[14:0], mdl_lfsr[15] ^ mdl_lfsr[13] ^ mdl_lfsr[12] ^ mdl_lfsr[10]};
      check($sformatf("jit_phase_%0d", n), o_phase, mdl_phase);
    end
    check("jit_output", {31'h0, o_output}, {31'h0, mdl_phase[31]});
    check("jit_lfsr_period", {16'h0, mdl_lfsr}, 32'h0000_0001);
    $display("jitter: 65535 ce, final phase=0x%08h", o_phase);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
